micro_sequencer: RTL and testbench

- Microprogram sequencer, directly downstream of the jump/branch decode stage.
- Consumes that stage's decoded controls (pre_load, is_BSR, is_RET) and its 10-bit target S.
- Holds the registered micro-PC that addresses the microinstruction ROM.
- Owns a LIFO return-address stack for BSR/RET.

---
 rtl/micro_sequencer.sv | 78 +++++++
 tb/tb_micro_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered micro-PC plus a LIFO return-address stack; 1-cycle latency, stall holds all state.
// Define SEQ_STACK_GUARD_EN to drop a push on a full stack and flag it in stack_err (default: circular overwrite of the oldest entry).
module micro_sequencer #(
  parameter int                ADDR_W      = 10,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         pre_load,
  input  logic                         is_BSR,
  input  logic                         is_RET,
  input  logic [ADDR_W-1:0]            S,
  output logic [ADDR_W-1:0]            upc,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         stack_empty,
  output logic                         stack_full,
  output logic                         stack_err
);

  localparam int            PW   = $clog2(STACK_DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     top;
  logic [ADDR_W-1:0] upc_inc;

  // wp always points one past the newest entry; it wraps, so on a full
  // stack it also addresses the oldest entry.
  assign top         = wp - PW'(1);
  assign upc_inc     = upc + ADDR_W'(1);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      upc       <= RESET_ADDR;
      sp        <= '0;
      wp        <= '0;
      stack_err <= 1'b0;
    end else if (!stall) begin
      if (is_RET) begin
        if (stack_empty) begin
          upc       <= RESET_ADDR;
          stack_err <= 1'b1;
        end else begin
          upc <= stack[top];
          wp  <= top;
          sp  <= sp - (PW+1)'(1);
        end
      end else if (is_BSR) begin
        upc <= S;
`ifdef SEQ_STACK_GUARD_EN
        if (stack_full) begin
          stack_err <= 1'b1;
        end else begin
          stack[wp] <= upc_inc;
          wp        <= wp + PW'(1);
          sp        <= sp + (PW+1)'(1);
        end
`else
        stack[wp] <= upc_inc;
        wp        <= wp + PW'(1);
        if (!stack_full) begin
          sp <= sp + (PW+1)'(1);
        end
`endif
      end else if (pre_load) begin
        upc <= S;
      end else begin
        upc <= upc_inc;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus random traffic against a queue-based reference model.
module tb_micro_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset, stall, pre_load, is_BSR, is_RET;
  logic [9:0] S;
  logic [9:0] upc;
  logic [2:0] sp;
  logic       stack_empty, stack_full, stack_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SEQ_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // reference model state
  int unsigned m_upc;
  int unsigned rs[$];
  bit          m_err;

  micro_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .pre_load(pre_load),
    .is_BSR(is_BSR), .is_RET(is_RET), .S(S), .upc(upc), .sp(sp),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, st, pl, b, rt, input int unsigned s);
    if (r) begin
      m_upc = 0; rs.delete(); m_err = 0;
    end else if (st) begin
    end else if (rt) begin
      if (rs.size() == 0) begin m_upc = 0; m_err = 1; end
      else m_upc = rs.pop_back();
    end else if (b) begin
      if (rs.size() == D) begin
        if (GUARD) m_err = 1;
        else begin void'(rs.pop_front()); rs.push_back((m_upc + 1) % 1024); end
      end else rs.push_back((m_upc + 1) % 1024);
      m_upc = s;
    end else if (pl) m_upc = s;
    else m_upc = (m_upc + 1) % 1024;
  endtask

  task automatic step(input bit r, st, pl, b, rt, input logic [9:0] s);
    reset = r; stall = st; pre_load = pl; is_BSR = b; is_RET = rt; S = s;
    @(posedge clk);
    model(r, st, pl, b, rt, s);
    #1;
    chk("upc", upc, m_upc);
    chk("sp", sp, rs.size());
    chk("empty", stack_empty, rs.size() == 0);
    chk("full", stack_full, rs.size() == D);
    chk("err", stack_err, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 10'h0);
  endtask
  task automatic jump(input logic [9:0] s); step(0, 0, 1, 0, 0, s); endtask
  task automatic bsr(input logic [9:0] s);  step(0, 0, 1, 1, 0, s); endtask
  task automatic ret();                     step(0, 0, 1, 0, 1, 10'h0); endtask

  initial begin
    reset = 1; stall = 0; pre_load = 0; is_BSR = 0; is_RET = 0; S = '0;
    m_upc = 0; m_err = 0;

    // sequential run and mid-run reset
    step(1, 0, 0, 0, 0, 10'h0);
    chk("rst_upc", upc, 0);
    idle(5);
    chk("seq_upc5", upc, 5);
    idle(13);
    chk("pre_rst_upc", upc, 'h12);
    step(1, 0, 0, 0, 0, 10'h0);
    chk("mid_rst_upc", upc, 0);

    // jump and stall
    idle(3);
    jump(10'h155);
    chk("jump_upc", upc, 'h155);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 10'h020);
    chk("stall_hold", upc, 'h156);

    // call / return
    jump(10'h010);
    bsr(10'h200);
    chk("call_upc", upc, 'h200);
    chk("call_sp", sp, 1);
    idle(2);
    ret();
    chk("ret_upc", upc, 'h011);
    chk("ret_err", stack_err, 0);

    // nested calls to full, then unwind
    jump(10'h001);
    bsr(10'h101); bsr(10'h201); bsr(10'h301); bsr(10'h050);
    chk("nest_full", stack_full, 1);
    ret(); chk("unwind0", upc, 'h302);
    ret(); chk("unwind1", upc, 'h202);
    ret(); chk("unwind2", upc, 'h102);
    ret(); chk("unwind3", upc, 'h002);

    // overflow
    jump(10'h001);
    bsr(10'h101); bsr(10'h201); bsr(10'h301); bsr(10'h050);
    bsr(10'h060);
    chk("ovf_upc", upc, 'h060);
    chk("ovf_sp", sp, 4);
    chk("ovf_err", stack_err, GUARD);
    ret();
    chk("ovf_ret", upc, GUARD ? 'h302 : 'h051);
    ret(); ret(); ret();

    // underflow, sticky error
    step(1, 0, 0, 0, 0, 10'h0);
    jump(10'h0AA);
    ret();
    chk("udf_upc", upc, 0);
    chk("udf_err", stack_err, 1);
    idle(3);
    jump(10'h3FF);
    chk("err_sticky", stack_err, 1);

    // wrap of the return address
    bsr(10'h100);
    ret();
    chk("wrap_ret", upc, 0);

    // illegal BSR+RET: pop only
    jump(10'h040);
    bsr(10'h123);
    step(0, 0, 1, 1, 1, 10'h2AA);
    chk("both_upc", upc, 'h041);
    chk("both_sp", sp, 0);

    // random traffic
    step(1, 0, 0, 0, 0, 10'h0);
    for (int i = 0; i < 3000; i++) begin
      int unsigned op;
      bit r, st, pl, b, rt;
      op = $urandom_range(0, 11);
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 7) == 0);
      pl = (op < 8) ? 1'b1 : ($urandom_range(0, 3) == 0);
      b  = (op <= 2) || (op == 6) || (op == 8);
      rt = (op >= 3 && op <= 5) || (op == 6) || (op == 9);
      step(r, st, pl, b, rt, 10'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
